otter_uart_tx: RTL

Memory-mapped UART transmitter on the OTTER IOBUS, one stage downstream of the wrapper's IOBUS output decode, alongside the LED and seven-segment registers. The CPU writes bytes to a data address. The bytes are queued in a small FIFO and serialized 8N1 on a single TX pin at a fixed baud rate. A status address lets firmware poll full/busy/overflow before writing.

---
 rtl/otter_uart_tx.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/otter_uart_tx.sv
// OTTER IOBUS UART transmitter: byte FIFO feeding an 8N1 serializer with a pollable status word.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module otter_uart_tx #(
  parameter int          CLK_HZ     = 50_000_000,
  parameter int          BAUD       = 115200,
  parameter logic [31:0] DATA_AD    = 32'h11000060,
  parameter logic [31:0] STAT_AD    = 32'h11000064,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] RD_DATA,
  output logic        TX,
  output logic        TX_BUSY
);

  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] RELOAD  = CW'(DIV - 1);
  localparam logic [AW:0]   DEPTH_C = FIFO_DEPTH[AW:0];
  localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};
`ifdef UART_TX_PARITY_EN
  localparam logic PAR_PRESENT = 1'b1;
`else
  localparam logic PAR_PRESENT = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wptr, rptr, wptr_n, rptr_n, count, count_n;
  logic [7:0]    head;
  logic          full, empty, push_req, push, pop, drop, ovf, ovf_clr;
  logic          tx_n, busy_n, unused_bits;
`ifdef UART_TX_PARITY_EN
  logic          par, par_n;
`endif

  assign unused_bits = ^IOBUS_OUT[31:8];
  assign head     = mem[rptr[AW-1:0]];
  assign count    = wptr - rptr;
  assign empty    = (wptr == rptr);
  assign full     = (count == DEPTH_C);
  assign push_req = IOBUS_WR && (IOBUS_ADDR == DATA_AD);
  // A pop in the same cycle frees the slot the push lands in, so a full FIFO still accepts it.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;
  assign ovf_clr  = IOBUS_WR && (IOBUS_ADDR == STAT_AD) && IOBUS_OUT[2];
  assign wptr_n   = push ? wptr + PTR_ONE : wptr;
  assign rptr_n   = pop ? rptr + PTR_ONE : rptr;
  assign count_n  = wptr_n - rptr_n;

  assign RD_DATA = (IOBUS_ADDR == STAT_AD) ?
                   {19'd0, 5'(count), 4'd0, PAR_PRESENT, ovf, TX_BUSY, full} : 32'd0;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n   = par;
`endif
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_n = head;
`ifdef UART_TX_PARITY_EN
          par_n   = ^head;
`endif
          state_n = S_START;
          cnt_n   = RELOAD;
        end
      end
      S_START: begin
        if (cnt == '0) begin
          state_n = S_DATA;
          idx_n   = 3'd0;
          cnt_n   = RELOAD;
        end else cnt_n = cnt - CW'(1);
      end
      S_DATA: begin
        if (cnt == '0) begin
          cnt_n   = RELOAD;
          shift_n = shift >> 1;
          if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end else idx_n = idx + 3'd1;
        end else cnt_n = cnt - CW'(1);
      end
      S_PARITY: begin
        if (cnt == '0) begin
          state_n = S_STOP;
          cnt_n   = RELOAD;
        end else cnt_n = cnt - CW'(1);
      end
      S_STOP: begin
        if (cnt == '0) begin
          cnt_n = RELOAD;
          // Chain straight into the next start bit so queued bytes leave with no idle gap.
          if (!empty) begin
            pop     = 1'b1;
            shift_n = head;
`ifdef UART_TX_PARITY_EN
            par_n   = ^head;
`endif
            state_n = S_START;
          end else state_n = S_IDLE;
        end else cnt_n = cnt - CW'(1);
      end
      default: state_n = S_IDLE;
    endcase

    case (state_n)
      S_START:  tx_n = 1'b0;
      S_DATA:   tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_n = par_n;
`endif
      default:  tx_n = 1'b1;
    endcase
    busy_n = (count_n != '0) || (state_n != S_IDLE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      wptr    <= '0;
      rptr    <= '0;
      ovf     <= 1'b0;
      TX      <= 1'b1;
      TX_BUSY <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      shift   <= shift_n;
      wptr    <= wptr_n;
      rptr    <= rptr_n;
      ovf     <= drop | (ovf & ~ovf_clr);
      TX      <= tx_n;
      TX_BUSY <= busy_n;
`ifdef UART_TX_PARITY_EN
      par     <= par_n;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wptr[AW-1:0]] <= IOBUS_OUT[7:0];
  end

endmodule
